grid_peel_engine: RTL and testbench
===================================

# grid_peel_engine

Row-serial, multi-pass successor to the combinational accessibility sweep. A DEPTH×WIDTH occupancy grid is loaded one row per beat, then peeled in repeated synchronous passes: each pass removes every occupied cell with fewer than THRESHOLD occupied 8-neighbours. The block runs either a single pass or passes to a fixpoint, bounded by a pass cap, and reports per-pass and total removal counts plus the final grid. It sits between the puzzle-input row streamer and the result/score logic.

## Interface
- WIDTH, 16, cells per row
- DEPTH, 16, rows in the grid (≥2)
- THRESHOLD, 4, cell removed when its occupied-neighbour count < THRESHOLD (1..8)
- MAX_PASSES, 255, hard cap on passes per run (≥1)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  pulse in IDLE; begins a run and enters LOAD
- mode  in  1  sampled with start: 0 = single pass, 1 = run to fixpoint
- load_valid  in  1  load_row valid
- load_ready  out  1  high only in LOAD
- load_row  in  WIDTH  row data, bit j = column j, 1 = occupied
- rd_addr  in  $clog2(DEPTH)  final-grid row select
- rd_row  out  WIDTH  combinational read of stored row rd_addr (valid in DONE)
- pass_removed  out  CNT_W  cells removed in the most recent pass
- total_removed  out  CNT_W  cells removed this run
- pass_count  out  PASS_W  passes completed this run
- busy  out  1  high in LOAD, SWEEP, CHECK
- done  out  1  high in DONE until next start

## Operation
- CNT_W = $clog2(WIDTH*DEPTH+1); PASS_W = $clog2(MAX_PASSES+1). Counters never wrap at these widths.
- States: IDLE → LOAD → SWEEP → CHECK → (SWEEP | DONE); DONE → LOAD on start. start ignored outside IDLE/DONE.
- On start: latch mode, clear pass_removed, total_removed, pass_count, done; row pointer = 0.
- LOAD: each load_valid&&load_ready beat writes load_row to grid[ptr], ptr++. After row DEPTH-1 → SWEEP, ptr = 0.
- SWEEP: one row per cycle, r = 0..DEPTH-1. Decisions for row r use the grid as it stood at pass start (Jacobi semantics): a prev-row register holds the pre-update row r-1; rows r and r+1 are read from the array (not yet updated). Out-of-grid neighbours count as 0. Updated row r written back the same cycle; popcount of cleared bits accumulated into pass_removed.
- CHECK (1 cycle): total_removed += pass_removed, pass_count++. Go to DONE if mode==0, or pass_removed==0, or pass_count reaches MAX_PASSES; else clear pass_removed and re-enter SWEEP at r = 0.
- pass_removed holds the last pass value in DONE; the terminating zero pass counts in pass_count.
- Unoccupied cells never change; removal only clears bits.

## Timing
- Reset (async assert, sync release): state IDLE, load_ready 0, busy 0, done 0, all counters 0, grid cleared to 0, rd_row 0.
- Reset mid-LOAD/SWEEP: run abandoned immediately; no partial done.
- LOAD: zero-bubble; DEPTH accepted beats minimum. load_valid while load_ready low is ignored.
- Each pass = DEPTH SWEEP cycles + 1 CHECK cycle. done rises the cycle after the final CHECK.
- Run latency from last load beat to done = P·(DEPTH+1) + 1 cycles, P = passes executed.
- start in DONE on the same cycle as rd_addr read: read returns pre-start grid; LOAD begins next cycle.

## Structure
- Shared package grid_pkg: state enum (IDLE, LOAD, SWEEP, CHECK, DONE), CNT_W/PASS_W width functions.
- One sub-module: grid_row_peel — combinational; inputs row above, row, row below, THRESHOLD parameter; outputs updated row and removed popcount. Reused by the top for every sweep cycle.

## Test plan
- 4×4 all ones, THRESHOLD 4, mode 1 → pass 1 removes 4 corners, pass 2 removes 0; total_removed 4, pass_count 2, rd_row 0 = 4'b0110.
- 4×4 single occupied cell at (1,2), mode 1 → total_removed 1, pass_count 2, all rd_row 0.
- All-zero grid, mode 1 → total_removed 0, pass_count 1, done after DEPTH+2 cycles from last load beat.
- 16×16 all ones, mode 0 → pass_count 1, total_removed 4, only corners cleared; then MAX_PASSES=2 on a peeling-chain grid → stops at pass_count 2 with pass_removed ≠ 0.
- load_valid toggled 50% during LOAD and asserted in IDLE → only DEPTH in-LOAD beats stored, grid matches.
- reset low mid-SWEEP pass 2 → busy/done/counters 0 next edge; new start + load runs cleanly to expected totals.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared types and width helpers for the grid peeling engine.
package grid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SWEEP,
    ST_CHECK,
    ST_DONE
  } state_t;

  function automatic int cnt_w(input int w, input int d);
    return $clog2(w * d + 1);
  endfunction

  function automatic int pass_w(input int max_passes);
    return $clog2(max_passes + 1);
  endfunction

endpackage

// File: rtl/grid_row_peel.sv
// Combinational single-row peel: clears occupied cells whose 8-neighbour count
// falls below THRESHOLD, using the pre-pass rows above and below.
module grid_row_peel #(
  parameter int WIDTH     = 16,
  parameter int THRESHOLD = 4,
  parameter int OUT_W     = 5
) (
  input  logic [WIDTH-1:0] i_above,
  input  logic [WIDTH-1:0] i_row,
  input  logic [WIDTH-1:0] i_below,
  output logic [WIDTH-1:0] o_row,
  output logic [OUT_W-1:0] o_removed
);

  // One zero column on each side so edge cells see out-of-grid neighbours as empty.
  logic [WIDTH+1:0] w_a;
  logic [WIDTH+1:0] w_r;
  logic [WIDTH+1:0] w_b;

  assign w_a = {1'b0, i_above, 1'b0};
  assign w_r = {1'b0, i_row, 1'b0};
  assign w_b = {1'b0, i_below, 1'b0};

  function automatic logic [3:0] nbr_count(input logic [WIDTH+1:0] a,
                                           input logic [WIDTH+1:0] r,
                                           input logic [WIDTH+1:0] b,
                                           input int j);
    return 4'(a[j]) + 4'(a[j+1]) + 4'(a[j+2]) +
           4'(r[j])              + 4'(r[j+2]) +
           4'(b[j]) + 4'(b[j+1]) + 4'(b[j+2]);
  endfunction

  always_comb begin
    o_row     = i_row;
    o_removed = '0;
    for (int j = 0; j < WIDTH; j++) begin
      if (i_row[j] && (int'(nbr_count(w_a, w_r, w_b, j)) < THRESHOLD)) begin
        o_row[j]  = 1'b0;
        o_removed = o_removed + OUT_W'(1);
      end
    end
  end

endmodule

// File: rtl/grid_peel_engine.sv
// Row-serial occupancy grid peeler: loads a grid one row per beat, then runs
// Jacobi-style peel passes (single or to fixpoint, capped) and reports counts.
module grid_peel_engine
  import grid_pkg::*;
#(
  parameter  int WIDTH      = 16,
  parameter  int DEPTH      = 16,
  parameter  int THRESHOLD  = 4,
  parameter  int MAX_PASSES = 255,
  localparam int CNT_W      = cnt_w(WIDTH, DEPTH),
  localparam int PASS_W     = pass_w(MAX_PASSES),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic              i_load_valid,
  output logic              o_load_ready,
  input  logic [WIDTH-1:0]  i_load_row,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [WIDTH-1:0]  o_rd_row,
  output logic [CNT_W-1:0]  o_pass_removed,
  output logic [CNT_W-1:0]  o_total_removed,
  output logic [PASS_W-1:0] o_pass_count,
  output logic              o_busy,
  output logic              o_done
);

  state_t              r_state;
  logic                r_mode;
  logic [AW-1:0]       r_ptr;
  logic [WIDTH-1:0]    r_grid [DEPTH];
  logic [WIDTH-1:0]    r_prev;
  logic [CNT_W-1:0]    r_pass_removed;
  logic [CNT_W-1:0]    r_total_removed;
  logic [PASS_W-1:0]   r_pass_count;
  logic                r_load_ready;
  logic                r_busy;
  logic                r_done;

  logic                w_last_row;
  logic [WIDTH-1:0]    w_cur;
  logic [WIDTH-1:0]    w_below;
  logic [WIDTH-1:0]    w_new;
  logic [CNT_W-1:0]    w_removed;
  logic [PASS_W-1:0]   w_pc_next;
  logic                w_stop;

  assign w_last_row = (r_ptr == AW'(DEPTH - 1));
  assign w_cur      = r_grid[r_ptr];
  assign w_below    = w_last_row ? '0 : r_grid[r_ptr + AW'(1)];
  assign w_pc_next  = r_pass_count + PASS_W'(1);
  assign w_stop     = !r_mode || (r_pass_removed == '0) ||
                      (w_pc_next == PASS_W'(MAX_PASSES));

  // r_prev carries the pre-update copy of row r-1, so every decision in a pass
  // sees the grid as it stood when the pass began.
  grid_row_peel #(
    .WIDTH    (WIDTH),
    .THRESHOLD(THRESHOLD),
    .OUT_W    (CNT_W)
  ) u_row_peel (
    .i_above  (r_prev),
    .i_row    (w_cur),
    .i_below  (w_below),
    .o_row    (w_new),
    .o_removed(w_removed)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state         <= ST_IDLE;
      r_mode          <= 1'b0;
      r_ptr           <= '0;
      r_prev          <= '0;
      r_pass_removed  <= '0;
      r_total_removed <= '0;
      r_pass_count    <= '0;
      r_load_ready    <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_grid[i] <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_mode          <= i_mode;
            r_ptr           <= '0;
            r_pass_removed  <= '0;
            r_total_removed <= '0;
            r_pass_count    <= '0;
            r_load_ready    <= 1'b1;
            r_busy          <= 1'b1;
            r_done          <= 1'b0;
            r_state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_load_valid) begin
            r_grid[r_ptr] <= i_load_row;
            if (w_last_row) begin
              r_ptr        <= '0;
              r_prev       <= '0;
              r_load_ready <= 1'b0;
              r_state      <= ST_SWEEP;
            end else begin
              r_ptr <= r_ptr + AW'(1);
            end
          end
        end
        ST_SWEEP: begin
          r_grid[r_ptr]  <= w_new;
          r_prev         <= w_cur;
          r_pass_removed <= r_pass_removed + w_removed;
          if (w_last_row) begin
            r_ptr   <= '0;
            r_state <= ST_CHECK;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        ST_CHECK: begin
          r_total_removed <= r_total_removed + r_pass_removed;
          r_pass_count    <= w_pc_next;
          if (w_stop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_pass_removed <= '0;
            r_prev         <= '0;
            r_state        <= ST_SWEEP;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rd_row        = (int'(i_rd_addr) < DEPTH) ? r_grid[i_rd_addr] : '0;
  assign o_load_ready    = r_load_ready;
  assign o_pass_removed  = r_pass_removed;
  assign o_total_removed = r_total_removed;
  assign o_pass_count    = r_pass_count;
  assign o_busy          = r_busy;
  assign o_done          = r_done;

endmodule

// File: tb/tb_grid_peel_engine.sv
// Scoreboard bench: a 4x4 engine (cap 255) and a 16x16 engine (cap 2) driven
// with directed and random grids, checked against a cell-level peel model.
module tb_grid_peel_engine;

  typedef struct packed {
    logic [255:0] g;
    logic [31:0]  pr;
    logic [31:0]  tot;
    logic [31:0]  pc;
  } res_t;

  localparam int THR = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic        start [2];
  logic        mode  [2];
  logic        lv    [2];
  logic [3:0]  a_lrow, a_rd;
  logic [15:0] b_lrow, b_rd;
  logic [1:0]  a_raddr;
  logic [3:0]  b_raddr;
  logic        a_lr, a_busy, a_done, b_lr, b_busy, b_done;
  logic [4:0]  a_pr, a_tot;
  logic [7:0]  a_pc;
  logic [8:0]  b_pr, b_tot;
  logic [1:0]  b_pc;

  logic        lr_v   [2];
  logic        busy_v [2];
  logic        done_v [2];
  logic [15:0] rd_v   [2];
  logic [15:0] pr_v   [2];
  logic [15:0] tot_v  [2];
  logic [15:0] pc_v   [2];

  assign lr_v[0] = a_lr;          assign lr_v[1] = b_lr;
  assign busy_v[0] = a_busy;      assign busy_v[1] = b_busy;
  assign done_v[0] = a_done;      assign done_v[1] = b_done;
  assign rd_v[0] = 16'(a_rd);     assign rd_v[1] = b_rd;
  assign pr_v[0] = 16'(a_pr);     assign pr_v[1] = 16'(b_pr);
  assign tot_v[0] = 16'(a_tot);   assign tot_v[1] = 16'(b_tot);
  assign pc_v[0] = 16'(a_pc);     assign pc_v[1] = 16'(b_pc);

  int   beat_cyc [2];
  bit   fin      [2];
  res_t q0[$];
  res_t q1[$];

  grid_peel_engine #(.WIDTH(4), .DEPTH(4), .THRESHOLD(THR), .MAX_PASSES(255)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[0]), .i_mode(mode[0]),
    .i_load_valid(lv[0]), .o_load_ready(a_lr), .i_load_row(a_lrow),
    .i_rd_addr(a_raddr), .o_rd_row(a_rd), .o_pass_removed(a_pr),
    .o_total_removed(a_tot), .o_pass_count(a_pc), .o_busy(a_busy), .o_done(a_done));

  grid_peel_engine #(.WIDTH(16), .DEPTH(16), .THRESHOLD(THR), .MAX_PASSES(2)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start[1]), .i_mode(mode[1]),
    .i_load_valid(lv[1]), .o_load_ready(b_lr), .i_load_row(b_lrow),
    .i_rd_addr(b_raddr), .o_rd_row(b_rd), .o_pass_removed(b_pr),
    .o_total_removed(b_tot), .o_pass_count(b_pc), .o_busy(b_busy), .o_done(b_done));

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d got=%0d want=%0d (t=%0t)", name, k, act, exp, $time);
    end
  endtask

  // Reference: repeated simultaneous peel passes over a cell array, row r at bits [r*16 +: 16].
  function automatic res_t model(input logic [255:0] g0, input bit md, input int w, input int d, input int maxp);
    res_t e;
    logic [255:0] g, nx;
    int cnt, n;
    g = g0; e = '0;
    do begin
      nx = g; cnt = 0;
      for (int r = 0; r < d; r++)
        for (int c = 0; c < w; c++)
          if (g[r*16+c]) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++)
                if (!(dr == 0 && dc == 0) && r+dr >= 0 && r+dr < d && c+dc >= 0 && c+dc < w)
                  n += int'(g[(r+dr)*16 + c + dc]);
            if (n < THR) begin nx[r*16+c] = 1'b0; cnt++; end
          end
      g = nx; e.pr = cnt; e.tot = e.tot + cnt; e.pc = e.pc + 1;
    end while (md && cnt != 0 && int'(e.pc) < maxp);
    e.g = g;
    return e;
  endfunction

  function automatic logic [255:0] rand_grid(input int w, input int d, input int pct);
    logic [255:0] g = '0;
    for (int r = 0; r < d; r++)
      for (int c = 0; c < w; c++) g[r*16+c] = ($urandom_range(0, 99) < pct);
    return g;
  endfunction

  task automatic set_row(input int k, input logic [15:0] row);
    if (k == 0) a_lrow = row[3:0]; else b_lrow = row;
  endtask

  task automatic set_raddr(input int k, input int r);
    if (k == 0) a_raddr = 2'(r); else b_raddr = 4'(r);
  endtask

  task automatic chk_reset_state(input int k);
    chk("rst_busy", k, 32'(busy_v[k]), 0);
    chk("rst_done", k, 32'(done_v[k]), 0);
    chk("rst_load_ready", k, 32'(lr_v[k]), 0);
    chk("rst_pass_removed", k, 32'(pr_v[k]), 0);
    chk("rst_total", k, 32'(tot_v[k]), 0);
    chk("rst_pass_count", k, 32'(pc_v[k]), 0);
    set_raddr(k, 0); #1;
    chk("rst_rd_row", k, 32'(rd_v[k]), 0);
  endtask

  // abort_at >= 0: pull reset that many cycles after the last load beat.
  task automatic run(input int k, input bit md, input logic [255:0] g, input int vpct, input int abort_at);
    int w, d, maxp, r, guard;
    bit v;
    res_t e;
    w = (k == 0) ? 4 : 16; d = w; maxp = (k == 0) ? 255 : 2;
    e = model(g, md, w, d, maxp);
    fin[k] = 1'b0;
    @(negedge clk);
    start[k] = 1'b1; mode[k] = md; lv[k] = 1'b1; set_row(k, 16'($urandom));
    if (abort_at < 0) begin
      if (k == 0) q0.push_back(e); else q1.push_back(e);
    end
    @(negedge clk);
    start[k] = 1'b0;
    r = 0; guard = 0;
    while (r < d && guard < 2000) begin
      v = ($urandom_range(0, 99) < vpct);
      lv[k] = v;
      set_row(k, v ? g[r*16 +: 16] : 16'($urandom));
      if (v && lr_v[k]) begin
        r++;
        if (r == d) beat_cyc[k] = cyc + 1;
      end
      @(negedge clk);
      guard++;
    end
    lv[k] = 1'b0;
    if (r != d) chk("load_timeout", k, 32'(r), 32'(d));
    if (abort_at >= 0) begin
      repeat (abort_at) @(negedge clk);
      chk("busy_before_abort", k, 32'(busy_v[k]), 1);
      rst_n = 1'b0; #1;
      chk_reset_state(k);
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      guard = 0;
      while (!fin[k] && guard < 5000) begin @(negedge clk); guard++; end
      if (!fin[k]) chk("done_timeout", k, 0, 1);
    end
  endtask

  task automatic mon(input int k);
    bit   pd = 1'b0;
    res_t e;
    int   d;
    d = (k == 0) ? 4 : 16;
    forever begin
      @(negedge clk);
      if (done_v[k] && !pd) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          chk("unexpected_done", k, 1, 0);
        end else begin
          if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk("pass_removed", k, 32'(pr_v[k]), e.pr);
          chk("total_removed", k, 32'(tot_v[k]), e.tot);
          chk("pass_count", k, 32'(pc_v[k]), e.pc);
          chk("latency", k, 32'(cyc - beat_cyc[k] + 1), e.pc * 32'(d + 1) + 1);
          for (int r = 0; r < d; r++) begin
            set_raddr(k, r); #1;
            chk("rd_row", k, 32'(rd_v[k]), 32'(e.g[r*16 +: 16]));
          end
          fin[k] = 1'b1;
        end
      end
      pd = done_v[k];
    end
  endtask

  initial mon(0);
  initial mon(1);

  initial begin
    #2000000;
    $display("FAIL watchdog dut- got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] ones4, ones16, g;
    res_t m;
    ones4 = '0; ones16 = '0;
    for (int r = 0; r < 4; r++) ones4[r*16 +: 16] = 16'h000F;
    for (int r = 0; r < 16; r++) ones16[r*16 +: 16] = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin start[k] = 0; mode[k] = 0; lv[k] = 0; end
    a_lrow = '0; b_lrow = '0; a_raddr = '0; b_raddr = '0;

    repeat (3) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    @(negedge clk);
    rst_n = 1'b1;

    run(0, 1'b1, ones4, 100, -1);
    g = '0; g[1*16+2] = 1'b1;
    run(0, 1'b1, g, 100, -1);
    run(0, 1'b1, '0, 100, -1);
    run(0, 1'b1, ones4, 50, -1);
    run(0, 1'b1, ones4, 100, 4 + 3);
    run(0, 1'b1, ones4, 100, -1);

    run(1, 1'b0, ones16, 100, -1);
    g = rand_grid(16, 16, 75);
    for (int t = 0; t < 50; t++) begin
      m = model(g, 1'b1, 16, 16, 2);
      if (m.pc == 2 && m.pr != 0) break;
      g = rand_grid(16, 16, 75);
    end
    run(1, 1'b1, g, 80, -1);

    for (int i = 0; i < 20; i++)
      run(0, 1'($urandom_range(0, 1)), rand_grid(4, 4, $urandom_range(20, 95)), 70, -1);
    for (int i = 0; i < 3; i++)
      run(1, 1'($urandom_range(0, 1)), rand_grid(16, 16, $urandom_range(40, 90)), 70, -1);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
